// File: rtl/riscv_core_rob_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_rob_pkg
// Purpose  : Shared ROB entry layout, slot-width helper and default sizing.
// Revision : 1.0
// ============================================================================
package riscv_core_rob_pkg;

  localparam int ROB_DEF_DEPTH  = 16;
  localparam int ROB_DEF_PREG_W = 5;
  localparam int ROB_DEF_N_FILL = 2;

  // Per-slot status flags; the destination register index is stored alongside
  // in a PREG_W-wide array because its width is a module parameter.
  typedef struct packed {
    logic valid;
    logic pending;
    logic wen;
    logic exc;
  } rob_flags_t;

  function automatic int rob_slot_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_core_rob_ptr.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_rob_ptr
// Purpose  : Wrap-bit pointer register with increment and clear.
// Revision : 1.0
// ============================================================================
module riscv_core_rob_ptr #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + W'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/riscv_core_rob_param.sv
`default_nettype none
// ============================================================================
// Module   : riscv_core_rob_param
// Purpose  : Parametrised in-order-commit reorder buffer, N_FILL writebacks.
// Revision : 1.0
// ============================================================================
module riscv_core_rob_param
  import riscv_core_rob_pkg::*;
#(
  parameter  int DEPTH  = ROB_DEF_DEPTH,
  parameter  int PREG_W = ROB_DEF_PREG_W,
  parameter  int N_FILL = ROB_DEF_N_FILL,
  localparam int SLOT_W = rob_slot_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rob_alloc_req_val,
  output logic                     rob_alloc_req_rdy,
  input  logic                     rob_alloc_req_wen,
  input  logic [PREG_W-1:0]        rob_alloc_req_preg,
  output logic [SLOT_W-1:0]        rob_alloc_resp_slot,
  input  logic [N_FILL-1:0]        rob_fill_val,
  input  logic [N_FILL*SLOT_W-1:0] rob_fill_slot,
  input  logic [N_FILL-1:0]        rob_fill_exc,
  output logic                     rob_commit_val,
  output logic                     rob_commit_wen,
  output logic [SLOT_W-1:0]        rob_commit_slot,
  output logic [PREG_W-1:0]        rob_commit_rf_waddr,
  output logic                     rob_commit_exc,
  output logic                     rob_flush,
  output logic [SLOT_W:0]          rob_count
);

  localparam logic [SLOT_W:0] c_depth_cnt = (SLOT_W+1)'(DEPTH);

  rob_flags_t        r_flags [DEPTH];
  logic [PREG_W-1:0] r_preg  [DEPTH];

  logic [SLOT_W:0]   w_head;
  logic [SLOT_W:0]   w_tail;
  logic [SLOT_W:0]   w_count;
  logic [SLOT_W-1:0] w_head_slot;
  logic [SLOT_W-1:0] w_tail_slot;
  logic              w_full;
  logic              w_commit_val;
  logic              w_commit_exc;
  logic              w_alloc_fire;
  rob_flags_t        w_head_flags;
  logic [DEPTH-1:0]  w_fill_hit;
  logic [DEPTH-1:0]  w_fill_exc;

  riscv_core_rob_ptr #(.W(SLOT_W+1)) u_head_ptr (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_commit_val && !w_commit_exc),
    .i_clear (w_commit_exc),
    .o_ptr   (w_head)
  );

  riscv_core_rob_ptr #(.W(SLOT_W+1)) u_tail_ptr (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_alloc_fire),
    .i_clear (w_commit_exc),
    .o_ptr   (w_tail)
  );

  assign w_count      = w_tail - w_head;
  assign w_full       = (w_count == c_depth_cnt);
  assign w_head_slot  = w_head[SLOT_W-1:0];
  assign w_tail_slot  = w_tail[SLOT_W-1:0];
  assign w_head_flags = r_flags[w_head_slot];

  // Commit looks only at pre-edge state, so a same-cycle fill cannot retire.
  assign w_commit_val = w_head_flags.valid && !w_head_flags.pending;
  assign w_commit_exc = w_commit_val && w_head_flags.exc;
  assign w_alloc_fire = rob_alloc_req_val && rob_alloc_req_rdy;

  assign rob_alloc_req_rdy   = !w_full && !w_commit_exc;
  assign rob_alloc_resp_slot = w_tail_slot;
  assign rob_commit_val      = w_commit_val;
  assign rob_commit_wen      = w_commit_val && w_head_flags.wen && !w_head_flags.exc;
  assign rob_commit_slot     = w_commit_val ? w_head_slot : '0;
  assign rob_commit_rf_waddr = w_commit_val ? r_preg[w_head_slot] : '0;
  assign rob_commit_exc      = w_commit_exc;
  assign rob_flush           = w_commit_exc;
  assign rob_count           = w_count;

  // Merge all fill lanes into per-slot hit and exception vectors.
  always_comb begin
    w_fill_hit = '0;
    w_fill_exc = '0;
    for (int k = 0; k < N_FILL; k++) begin
      if (rob_fill_val[k]) begin
        w_fill_hit[rob_fill_slot[k*SLOT_W +: SLOT_W]] = 1'b1;
        w_fill_exc[rob_fill_slot[k*SLOT_W +: SLOT_W]] =
          w_fill_exc[rob_fill_slot[k*SLOT_W +: SLOT_W]] | rob_fill_exc[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_flags[s] <= '0;
        r_preg[s]  <= '0;
      end
    end else if (w_commit_exc) begin
      for (int s = 0; s < DEPTH; s++) begin
        r_flags[s].valid   <= 1'b0;
        r_flags[s].pending <= 1'b0;
      end
    end else begin
      // Stale and duplicate fills miss the valid && pending qualifier.
      for (int s = 0; s < DEPTH; s++) begin
        if (w_fill_hit[s] && r_flags[s].valid && r_flags[s].pending) begin
          r_flags[s].pending <= 1'b0;
          r_flags[s].exc     <= r_flags[s].exc | w_fill_exc[s];
        end
      end
      if (w_commit_val) begin
        r_flags[w_head_slot].valid <= 1'b0;
      end
      if (w_alloc_fire) begin
        r_flags[w_tail_slot] <= '{valid: 1'b1, pending: 1'b1,
                                  wen: rob_alloc_req_wen, exc: 1'b0};
        r_preg[w_tail_slot]  <= rob_alloc_req_preg;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_core_rob_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_core_rob_param
// Purpose  : Self-checking bench: directed table, corner sequences, random run.
// Revision : 1.0
// ============================================================================
module tb_riscv_core_rob_param;

  localparam int DEPTH  = 16;
  localparam int PREG_W = 5;
  localparam int N_FILL = 2;
  localparam int SLOT_W = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     rob_alloc_req_val = 1'b0;
  logic                     rob_alloc_req_rdy;
  logic                     rob_alloc_req_wen = 1'b0;
  logic [PREG_W-1:0]        rob_alloc_req_preg = '0;
  logic [SLOT_W-1:0]        rob_alloc_resp_slot;
  logic [N_FILL-1:0]        rob_fill_val = '0;
  logic [N_FILL*SLOT_W-1:0] rob_fill_slot = '0;
  logic [N_FILL-1:0]        rob_fill_exc = '0;
  logic                     rob_commit_val;
  logic                     rob_commit_wen;
  logic [SLOT_W-1:0]        rob_commit_slot;
  logic [PREG_W-1:0]        rob_commit_rf_waddr;
  logic                     rob_commit_exc;
  logic                     rob_flush;
  logic [SLOT_W:0]          rob_count;

  riscv_core_rob_param #(.DEPTH(DEPTH), .PREG_W(PREG_W), .N_FILL(N_FILL)) dut (
    .clk                 (clk),
    .reset               (reset),
    .rob_alloc_req_val   (rob_alloc_req_val),
    .rob_alloc_req_rdy   (rob_alloc_req_rdy),
    .rob_alloc_req_wen   (rob_alloc_req_wen),
    .rob_alloc_req_preg  (rob_alloc_req_preg),
    .rob_alloc_resp_slot (rob_alloc_resp_slot),
    .rob_fill_val        (rob_fill_val),
    .rob_fill_slot       (rob_fill_slot),
    .rob_fill_exc        (rob_fill_exc),
    .rob_commit_val      (rob_commit_val),
    .rob_commit_wen      (rob_commit_wen),
    .rob_commit_slot     (rob_commit_slot),
    .rob_commit_rf_waddr (rob_commit_rf_waddr),
    .rob_commit_exc      (rob_commit_exc),
    .rob_flush           (rob_flush),
    .rob_count           (rob_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: an ordered list of in-flight instructions, oldest first.
  typedef struct {
    int slot;
    bit wen;
    int preg;
    bit done;
    bit exc;
  } ment_t;

  ment_t mq[$];
  int    mhead = 0;

  function automatic bit m_cval();
    return (mq.size() > 0) && mq[0].done;
  endfunction
  function automatic bit m_cexc();
    return m_cval() && mq[0].exc;
  endfunction
  function automatic bit m_rdy();
    return (mq.size() < DEPTH) && !m_cexc();
  endfunction

  task automatic check_model(input string tag);
    bit cv;
    cv = m_cval();
    chk({tag, " rdy"},    int'(rob_alloc_req_rdy),   int'(m_rdy()));
    chk({tag, " resp"},   int'(rob_alloc_resp_slot), (mhead + mq.size()) % DEPTH);
    chk({tag, " cval"},   int'(rob_commit_val),      int'(cv));
    chk({tag, " cwen"},   int'(rob_commit_wen),      int'(cv && mq[0].wen && !mq[0].exc));
    chk({tag, " cslot"},  int'(rob_commit_slot),     cv ? mq[0].slot : 0);
    chk({tag, " waddr"},  int'(rob_commit_rf_waddr), cv ? mq[0].preg : 0);
    chk({tag, " cexc"},   int'(rob_commit_exc),      int'(m_cexc()));
    chk({tag, " flush"},  int'(rob_flush),           int'(m_cexc()));
    chk({tag, " count"},  int'(rob_count),           mq.size());
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  function automatic void model_step();
    int    sz;
    bit    cv;
    bit    rdy;
    int    base;
    int    fs [N_FILL];
    bit    hit [DEPTH];
    bit    hex [DEPTH];
    ment_t e;
    sz   = mq.size();
    cv   = m_cval();
    rdy  = m_rdy();
    base = mhead;
    if (reset || m_cexc()) begin
      mq.delete();
      mhead = 0;
      return;
    end
    for (int j = 0; j < DEPTH; j++) begin
      hit[j] = 1'b0;
      hex[j] = 1'b0;
    end
    for (int k = 0; k < N_FILL; k++) fs[k] = int'(rob_fill_slot[k*SLOT_W +: SLOT_W]);
    for (int k = 0; k < N_FILL; k++) begin
      if (rob_fill_val[k]) begin
        for (int j = 0; j < sz; j++) begin
          if (mq[j].slot == fs[k] && !mq[j].done) begin
            hit[j] = 1'b1;
            hex[j] = hex[j] | rob_fill_exc[k];
          end
        end
      end
    end
    for (int j = 0; j < sz; j++) begin
      if (hit[j]) begin
        e      = mq[j];
        e.done = 1'b1;
        e.exc  = e.exc | hex[j];
        mq[j]  = e;
      end
    end
    if (cv) begin
      void'(mq.pop_front());
      mhead = (mhead + 1) % DEPTH;
    end
    if (rob_alloc_req_val && rdy) begin
      e.slot = (base + sz) % DEPTH;
      e.wen  = rob_alloc_req_wen;
      e.preg = int'(rob_alloc_req_preg);
      e.done = 1'b0;
      e.exc  = 1'b0;
      mq.push_back(e);
    end
  endfunction

  task automatic drive(input bit val, input bit wen, input int preg,
                       input int fval, input int s0, input int s1,
                       input int fexc, input bit rst);
    reset              = rst;
    rob_alloc_req_val  = val;
    rob_alloc_req_wen  = wen;
    rob_alloc_req_preg = PREG_W'(preg);
    rob_fill_val       = N_FILL'(fval);
    rob_fill_slot      = {SLOT_W'(s1), SLOT_W'(s0)};
    rob_fill_exc       = N_FILL'(fexc);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag);
    #1;
    check_model(tag);
    tick();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 1'b1);
    tick();
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  typedef struct packed {
    logic              val;
    logic              wen;
    logic [PREG_W-1:0] preg;
    logic [1:0]        fval;
    logic [3:0]        fs0;
    logic [3:0]        fs1;
    logic [1:0]        fexc;
    logic              rdy;
    logic [3:0]        resp;
    logic              cval;
    logic              cwen;
    logic [3:0]        cslot;
    logic [PREG_W-1:0] waddr;
    logic              cexc;
    logic [4:0]        count;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input int val, input int wen, input int preg, input int fval,
                         input int fs0, input int fs1, input int fexc, input int rdy,
                         input int resp, input int cval, input int cwen, input int cslot,
                         input int waddr, input int cexc, input int count);
    vec_t v;
    v.val = 1'(val);   v.wen = 1'(wen);   v.preg = PREG_W'(preg);
    v.fval = 2'(fval); v.fs0 = 4'(fs0);   v.fs1 = 4'(fs1);  v.fexc = 2'(fexc);
    v.rdy = 1'(rdy);   v.resp = 4'(resp); v.cval = 1'(cval); v.cwen = 1'(cwen);
    v.cslot = 4'(cslot); v.waddr = PREG_W'(waddr); v.cexc = 1'(cexc);
    v.count = 5'(count);
    tbl.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    string tag;
    int    s0;
    int    s1;

    //       val wen preg fv s0 s1 fx | rdy resp cv cw cs wa ce cnt
    add_vec(1, 1,  7, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0, 0, 0);
    add_vec(0, 0,  0, 1, 0, 0, 0,   1, 1, 0, 0, 0,  0, 0, 1);
    add_vec(0, 0,  0, 0, 0, 0, 0,   1, 1, 1, 1, 0,  7, 0, 1);
    add_vec(0, 0,  0, 0, 0, 0, 0,   1, 1, 0, 0, 0,  0, 0, 0);
    add_vec(1, 1, 10, 0, 0, 0, 0,   1, 1, 0, 0, 0,  0, 0, 0);
    add_vec(1, 1, 11, 0, 0, 0, 0,   1, 2, 0, 0, 0,  0, 0, 1);
    add_vec(1, 1, 12, 0, 0, 0, 0,   1, 3, 0, 0, 0,  0, 0, 2);
    add_vec(1, 1, 13, 1, 4, 0, 0,   1, 4, 0, 0, 0,  0, 0, 3);
    add_vec(0, 0,  0, 1, 3, 0, 0,   1, 5, 0, 0, 0,  0, 0, 4);
    add_vec(0, 0,  0, 1, 2, 0, 0,   1, 5, 0, 0, 0,  0, 0, 4);
    add_vec(0, 0,  0, 0, 0, 0, 0,   1, 5, 0, 0, 0,  0, 0, 4);
    add_vec(0, 0,  0, 2, 0, 1, 0,   1, 5, 0, 0, 0,  0, 0, 4);
    add_vec(0, 0,  0, 0, 0, 0, 0,   1, 5, 1, 1, 1, 10, 0, 4);
    add_vec(0, 0,  0, 0, 0, 0, 0,   1, 5, 1, 1, 2, 11, 0, 3);
    add_vec(0, 0,  0, 0, 0, 0, 0,   1, 5, 1, 1, 3, 12, 0, 2);
    add_vec(0, 0,  0, 0, 0, 0, 0,   1, 5, 0, 0, 0,  0, 0, 1);
    add_vec(0, 0,  0, 1, 4, 0, 0,   1, 5, 0, 0, 0,  0, 0, 1);
    add_vec(0, 0,  0, 0, 0, 0, 0,   1, 5, 1, 1, 4, 13, 0, 1);
    add_vec(0, 0,  0, 0, 0, 0, 0,   1, 5, 0, 0, 0,  0, 0, 0);
    add_vec(1, 1, 20, 0, 0, 0, 0,   1, 5, 0, 0, 0,  0, 0, 0);
    add_vec(1, 1, 21, 1, 5, 0, 0,   1, 6, 0, 0, 0,  0, 0, 1);
    add_vec(1, 1, 22, 2, 0, 6, 0,   1, 7, 1, 1, 5, 20, 0, 2);
    add_vec(0, 0,  0, 3, 7, 7, 2,   1, 8, 1, 1, 6, 21, 0, 2);
    add_vec(1, 1,  9, 0, 0, 0, 0,   0, 8, 1, 0, 7, 22, 1, 1);
    add_vec(0, 0,  0, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0, 0, 0);
    add_vec(1, 0,  3, 0, 0, 0, 0,   1, 0, 0, 0, 0,  0, 0, 0);
    add_vec(0, 0,  0, 3, 0, 5, 2,   1, 1, 0, 0, 0,  0, 0, 1);
    add_vec(0, 0,  0, 1, 0, 0, 1,   1, 1, 1, 0, 0,  3, 0, 1);
    add_vec(0, 0,  0, 0, 0, 0, 0,   1, 1, 0, 0, 0,  0, 0, 0);

    // Reset state
    #1;
    do_reset();
    #1;
    chk("reset rdy",   int'(rob_alloc_req_rdy),   1);
    chk("reset resp",  int'(rob_alloc_resp_slot), 0);
    chk("reset cval",  int'(rob_commit_val),      0);
    chk("reset cwen",  int'(rob_commit_wen),      0);
    chk("reset cexc",  int'(rob_commit_exc),      0);
    chk("reset flush", int'(rob_flush),           0);
    chk("reset count", int'(rob_count),           0);

    // Back-to-back allocation until full, then one refused request
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, i, 0, 0, 0, 0, 1'b0);
      #1;
      chk($sformatf("fill%0d resp", i), int'(rob_alloc_resp_slot), i);
      chk($sformatf("fill%0d rdy", i),  int'(rob_alloc_req_rdy),   1);
      tick();
    end
    chk("full rdy",   int'(rob_alloc_req_rdy), 0);
    chk("full count", int'(rob_count),         DEPTH);
    drive(1, 1, 30, 0, 0, 0, 0, 1'b0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0);
    #1;
    chk("refused count", int'(rob_count),           DEPTH);
    chk("refused resp",  int'(rob_alloc_resp_slot), 0);
    chk("refused cval",  int'(rob_commit_val),      0);

    // Directed vector table
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].val, tbl[i].wen, int'(tbl[i].preg), int'(tbl[i].fval),
            int'(tbl[i].fs0), int'(tbl[i].fs1), int'(tbl[i].fexc), 1'b0);
      #1;
      chk($sformatf("vec%0d rdy", i),   int'(rob_alloc_req_rdy),   int'(tbl[i].rdy));
      chk($sformatf("vec%0d resp", i),  int'(rob_alloc_resp_slot), int'(tbl[i].resp));
      chk($sformatf("vec%0d cval", i),  int'(rob_commit_val),      int'(tbl[i].cval));
      chk($sformatf("vec%0d cwen", i),  int'(rob_commit_wen),      int'(tbl[i].cwen));
      chk($sformatf("vec%0d cslot", i), int'(rob_commit_slot),     int'(tbl[i].cslot));
      chk($sformatf("vec%0d waddr", i), int'(rob_commit_rf_waddr), int'(tbl[i].waddr));
      chk($sformatf("vec%0d cexc", i),  int'(rob_commit_exc),      int'(tbl[i].cexc));
      chk($sformatf("vec%0d flush", i), int'(rob_flush),           int'(tbl[i].cexc));
      chk($sformatf("vec%0d count", i), int'(rob_count),           int'(tbl[i].count));
      tick();
    end

    // Steady state around a full buffer with slot wrap, then mid-stream reset
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, i[0], i + 3, 0, 0, 0, 0, 1'b0);
      cyc($sformatf("ss_fill%0d", i));
    end
    for (int i = 0; i < 40; i++) begin
      s0 = mhead;
      s1 = (mhead + 1) % DEPTH;
      drive(1, 1, i % 32, 3, s0, s1, 0, 1'b0);
      cyc($sformatf("ss%0d", i));
    end
    drive(1, 1, 1, 3, mhead, (mhead + 1) % DEPTH, 0, 1'b1);
    cyc("ss_reset");
    drive(0, 0, 0, 0, 0, 0, 0, 1'b0);
    #1;
    chk("midreset count", int'(rob_count),      0);
    chk("midreset cval",  int'(rob_commit_val), 0);
    chk("midreset rdy",   int'(rob_alloc_req_rdy), 1);

    // Randomised traffic against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      s0 = (mq.size() > 0 && $urandom_range(0, 3) != 0)
           ? mq[$urandom_range(0, mq.size() - 1)].slot : int'($urandom_range(0, DEPTH - 1));
      s1 = (mq.size() > 0 && $urandom_range(0, 3) != 0)
           ? mq[$urandom_range(0, mq.size() - 1)].slot : int'($urandom_range(0, DEPTH - 1));
      drive($urandom_range(0, 3) != 0, 1'($urandom), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 3)), s0, s1,
            {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)},
            $urandom_range(0, 199) == 0);
      tag = $sformatf("rnd%0d", i);
      cyc(tag);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
